// File: rtl/qlearn_round_ctrl.sv
// Per-node Q-learning round controller: reads own best and neighbor tables,
// picks the best neighbor, hands off to winnerPolicy, writes back nexthop.
//
// Ports:
//   clock, nreset            : rising-edge clock, async active-high reset
//   start, neighbor_count    : round request and neighbor entry count
//   MY_NODE_ID               : own node ID (default best neighbor)
//   epsilon_init/step_in     : epsilon reset value and per-round decrement
//   mem_select/address/...   : shared memory port (sync read, 1-cycle latency)
//   start/done_winnerPolicy  : initiator side of winnerPolicy handshake
//   mybest, best*, epsilon*  : winnerPolicy operands
//   nexthop / nexthop_out    : winnerPolicy result and its latched copy
//   done, busy               : round-complete pulse, activity flag
module qlearn_round_ctrl #(
    parameter int              WORD_WIDTH    = 16,
    parameter int              MAX_NEIGHBORS = 8,
    parameter logic [WORD_WIDTH-1:0] VALUE_BASE   = 16'h0100,
    parameter logic [WORD_WIDTH-1:0] HOP_BASE     = 16'h0120,
    parameter logic [WORD_WIDTH-1:0] ID_BASE      = 16'h0140,
    parameter logic [WORD_WIDTH-1:0] MYBEST_ADDR  = 16'h0160,
    parameter logic [WORD_WIDTH-1:0] NEXTHOP_ADDR = 16'h0161
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] neighbor_count,
    input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
    input  logic [WORD_WIDTH-1:0] epsilon_init,
    input  logic [WORD_WIDTH-1:0] epsilon_step_in,
    output logic                  mem_select,
    output logic [WORD_WIDTH-1:0] mem_address,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  start_winnerPolicy,
    output logic [WORD_WIDTH-1:0] mybest,
    output logic [WORD_WIDTH-1:0] besthop,
    output logic [WORD_WIDTH-1:0] bestvalue,
    output logic [WORD_WIDTH-1:0] bestneighborID,
    output logic [WORD_WIDTH-1:0] epsilon,
    output logic [WORD_WIDTH-1:0] epsilon_step,
    input  logic [WORD_WIDTH-1:0] nexthop,
    input  logic                  done_winnerPolicy,
    output logic [WORD_WIDTH-1:0] nexthop_out,
    output logic                  done,
    output logic                  busy
);

    localparam int IW = $clog2(MAX_NEIGHBORS + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WP_REQ,
        WRITE,
        FINISH
    } state_t;

    typedef enum logic [1:0] {
        PH_MYBEST,
        PH_VALUE,
        PH_HOP,
        PH_ID
    } phase_t;

    state_t state, state_next;

    logic [IW-1:0]         n_r;
    logic [IW-1:0]         n_clamp;

    // Issue side of the read pipeline
    logic                  iss_on;
    phase_t                iss_phase;
    logic [IW-1:0]         iss_idx;
    logic                  iss_last;
    logic [WORD_WIDTH-1:0] iss_addr;
    logic [WORD_WIDTH-1:0] addr_r;

    // Two-stage tag pipe: registered address, then sync memory latency
    logic                  p1_v, p2_v;
    phase_t                p1_ph, p2_ph;
    logic                  p1_last, p2_last;

    logic [WORD_WIDTH-1:0] val_tmp;
    logic [WORD_WIDTH-1:0] hop_tmp;

    assign n_clamp = (neighbor_count > WORD_WIDTH'(MAX_NEIGHBORS))
                   ? IW'(MAX_NEIGHBORS)
                   : neighbor_count[IW-1:0];

    assign iss_last = ((iss_phase == PH_MYBEST) && (n_r == '0))
                   || ((iss_phase == PH_ID) && ((iss_idx + IW'(1)) == n_r));

    assign epsilon_step = epsilon_step_in;

    always_comb begin
        iss_addr = MYBEST_ADDR;
        case (iss_phase)
            PH_VALUE: iss_addr = VALUE_BASE + WORD_WIDTH'(iss_idx);
            PH_HOP:   iss_addr = HOP_BASE + WORD_WIDTH'(iss_idx);
            PH_ID:    iss_addr = ID_BASE + WORD_WIDTH'(iss_idx);
            default:  iss_addr = MYBEST_ADDR;
        endcase
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        mem_select         = 1'b0;
        mem_address        = '0;
        mem_wr_en          = 1'b0;
        mem_data_in        = '0;
        start_winnerPolicy = 1'b0;
        done               = 1'b0;
        busy               = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                mem_select  = 1'b1;
                mem_address = addr_r;
                if (p2_v && p2_last) state_next = WP_REQ;
            end
            WP_REQ: begin
                start_winnerPolicy = 1'b1;
                if (done_winnerPolicy) state_next = WRITE;
            end
            WRITE: begin
                mem_select  = 1'b1;
                mem_address = NEXTHOP_ADDR;
                mem_data_in = nexthop_out;
                mem_wr_en   = 1'b1;
                state_next  = FINISH;
            end
            FINISH: begin
                mem_select = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge nreset) begin
        if (nreset) begin
            n_r            <= '0;
            iss_on         <= 1'b0;
            iss_phase      <= PH_MYBEST;
            iss_idx        <= '0;
            addr_r         <= '0;
            p1_v           <= 1'b0;
            p1_ph          <= PH_MYBEST;
            p1_last        <= 1'b0;
            p2_v           <= 1'b0;
            p2_ph          <= PH_MYBEST;
            p2_last        <= 1'b0;
            val_tmp        <= '0;
            hop_tmp        <= '0;
            mybest         <= '0;
            bestvalue      <= '0;
            besthop        <= '0;
            bestneighborID <= '0;
            nexthop_out    <= '0;
            epsilon        <= epsilon_init;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r            <= n_clamp;
                        iss_on         <= 1'b1;
                        iss_phase      <= PH_MYBEST;
                        iss_idx        <= '0;
                        addr_r         <= '0;
                        p1_v           <= 1'b0;
                        p2_v           <= 1'b0;
                        bestvalue      <= '1;
                        besthop        <= '0;
                        bestneighborID <= MY_NODE_ID;
                    end
                end
                READ: begin
                    p1_v    <= iss_on;
                    p1_ph   <= iss_phase;
                    p1_last <= iss_last;
                    p2_v    <= p1_v;
                    p2_ph   <= p1_ph;
                    p2_last <= p1_last;
                    if (iss_on) begin
                        addr_r <= iss_addr;
                        if (iss_last) begin
                            iss_on <= 1'b0;
                        end else begin
                            case (iss_phase)
                                PH_MYBEST: iss_phase <= PH_VALUE;
                                PH_VALUE:  iss_phase <= PH_HOP;
                                PH_HOP:    iss_phase <= PH_ID;
                                default: begin
                                    iss_phase <= PH_VALUE;
                                    iss_idx   <= iss_idx + IW'(1);
                                end
                            endcase
                        end
                    end else begin
                        addr_r <= '0;
                    end
                    if (p2_v) begin
                        case (p2_ph)
                            PH_MYBEST: mybest  <= mem_data_out;
                            PH_VALUE:  val_tmp <= mem_data_out;
                            PH_HOP:    hop_tmp <= mem_data_out;
                            default: begin
                                // strict compare: ties keep the lower index
                                if (val_tmp < bestvalue) begin
                                    bestvalue      <= val_tmp;
                                    besthop        <= hop_tmp;
                                    bestneighborID <= mem_data_out;
                                end
                            end
                        endcase
                    end
                end
                WP_REQ: begin
                    if (done_winnerPolicy) nexthop_out <= nexthop;
                end
                WRITE: begin
                    epsilon <= (epsilon >= epsilon_step_in)
                             ? epsilon - epsilon_step_in
                             : '0;
                end
                default: ;
            endcase
        end
    end

endmodule
